// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one outstanding icache request, JAL/BHT predecode of the
// returned word, and a circular instruction queue drained by the decoder.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IQ_DEPTH = 16,
  parameter int unsigned BHT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  output logic [31:0] IC_addr,
  output logic        IC_addr_sgn,
  input  logic [31:0] IC_val,
  input  logic        IC_val_sgn,
  input  logic        BR_upd,
  input  logic [31:0] BR_pc,
  input  logic        BR_taken,
  output logic        ID_valid,
  input  logic        ID_ready,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  output logic        ID_pred_jump,
  output logic [31:0] ID_pred_pc
);

  localparam int unsigned PtrW    = $clog2(IQ_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned BhtSize = 1 << BHT_BITS;
  localparam logic [CntW-1:0] DepthCnt = CntW'(IQ_DEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [0:0]      state_q;
  logic [31:0]     pc_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic [31:0] q_inst     [IQ_DEPTH];
  logic [31:0] q_pc       [IQ_DEPTH];
  logic        q_pred_jump[IQ_DEPTH];
  logic [31:0] q_pred_pc  [IQ_DEPTH];

  logic [1:0] bht_q [BhtSize];

  logic [BHT_BITS-1:0] br_idx;
  logic                unused_br_bits;
  logic [6:0]          opcode;
  logic [31:0]         j_imm, b_imm;
  logic [1:0]          bht_ctr;
  logic                pred_jump;
  logic [31:0]         pred_pc;
  logic                pop, push, req;

  assign br_idx         = BR_pc[BHT_BITS+1:2];
  assign unused_br_bits = ^{BR_pc[31:BHT_BITS+2], BR_pc[1:0]};

  // Predecode of the returned word against the PC it was fetched from.
  always_comb begin
    opcode    = IC_val[6:0];
    j_imm     = {{11{IC_val[31]}}, IC_val[31], IC_val[19:12], IC_val[20], IC_val[30:21], 1'b0};
    b_imm     = {{19{IC_val[31]}}, IC_val[31], IC_val[7], IC_val[30:25], IC_val[11:8], 1'b0};
    bht_ctr   = bht_q[pc_q[BHT_BITS+1:2]];
    pred_jump = 1'b0;
    pred_pc   = pc_q + 32'd4;
    if (opcode == OpJal) begin
      pred_jump = 1'b1;
      pred_pc   = pc_q + j_imm;
    end else if (opcode == OpBranch) begin
      pred_jump = bht_ctr[1];
      if (bht_ctr[1]) begin
        pred_pc = pc_q + b_imm;
      end
    end
  end

  always_comb begin
    ID_valid     = (count_q != '0);
    ID_inst      = ID_valid ? q_inst[head_q]      : 32'h0;
    ID_pc        = ID_valid ? q_pc[head_q]        : 32'h0;
    ID_pred_jump = ID_valid ? q_pred_jump[head_q] : 1'b0;
    ID_pred_pc   = ID_valid ? q_pred_pc[head_q]   : 32'h0;
    IC_addr      = pc_q;
  end

  // A pop frees a slot this cycle, so a full queue may still issue a request.
  always_comb begin
    pop  = rdy && !rollback && ID_valid && ID_ready;
    push = rdy && !rollback && (state_q == StWait) && IC_val_sgn;
    req  = rst_n && rdy && !rollback && (state_q == StIdle) &&
           ((count_q < DepthCnt) || (ID_valid && ID_ready));
    IC_addr_sgn = req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (rollback) begin
        state_q <= StIdle;
        pc_q    <= rollback_pc;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (req) begin
          state_q <= StWait;
        end else if (push) begin
          state_q <= StIdle;
          pc_q    <= pred_pc;
        end
        if (push) begin
          tail_q <= tail_q + 1'b1;
        end
        if (pop) begin
          head_q <= head_q + 1'b1;
        end
        if (push && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail_q]      <= IC_val;
      q_pc[tail_q]        <= pc_q;
      q_pred_jump[tail_q] <= pred_jump;
      q_pred_pc[tail_q]   <= pred_pc;
    end
  end

  // Updates apply even during rollback; only reset and a frozen stage block them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BhtSize; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (rdy && BR_upd) begin
      if (BR_taken && (bht_q[br_idx] != 2'b11)) begin
        bht_q[br_idx] <= bht_q[br_idx] + 2'd1;
      end else if (!BR_taken && (bht_q[br_idx] != 2'b00)) begin
        bht_q[br_idx] <= bht_q[br_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios then random traffic, all checked every
// cycle against a queue-based reference model with an icache responder.
module tb_ifetch_queue;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback, IC_addr_sgn, IC_val_sgn, BR_upd, BR_taken;
  logic        ID_valid, ID_ready, ID_pred_jump;
  logic [31:0] rollback_pc, IC_addr, IC_val, BR_pc, ID_inst, ID_pc, ID_pred_pc;

  always #5 clk = ~clk;

  ifetch_queue #(
    .RESET_PC(32'h0),
    .IQ_DEPTH(Depth),
    .BHT_BITS(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .rollback    (rollback),
    .rollback_pc (rollback_pc),
    .IC_addr     (IC_addr),
    .IC_addr_sgn (IC_addr_sgn),
    .IC_val      (IC_val),
    .IC_val_sgn  (IC_val_sgn),
    .BR_upd      (BR_upd),
    .BR_pc       (BR_pc),
    .BR_taken    (BR_taken),
    .ID_valid    (ID_valid),
    .ID_ready    (ID_ready),
    .ID_inst     (ID_inst),
    .ID_pc       (ID_pc),
    .ID_pred_jump(ID_pred_jump),
    .ID_pred_pc  (ID_pred_pc)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          pj;
    logic [31:0] ppc;
  } ent_t;

  // Reference model
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_init;
  int          m_bht[256];

  // Icache responder
  bit          ic_pend;
  int          ic_cnt;
  int          ic_lat;
  logic [31:0] ic_addr;
  bit          rand_prog, spur_en, force_sgn;

  logic [31:0] req_log[$];
  int          req_cyc[$];
  ent_t        pop_log[$];
  int          cyc;
  int          n_pass, n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0080006F;
      32'h20:  return 32'hFE000EE3;
      default: return 32'h00100093;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       op = 7'b1101111;
      1, 2:    op = 7'b1100011;
      3:       op = 7'b1100111;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  function automatic void predict(input logic [31:0] i, input logic [31:0] pc,
                                  output bit pj, output logic [31:0] ppc);
    int off;
    pj  = 1'b0;
    ppc = pc + 32'd4;
    if (i[6:0] == 7'b1101111) begin
      off = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      pj  = 1'b1;
      ppc = pc + off;
    end else if (i[6:0] == 7'b1100011) begin
      off = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      pj  = m_bht[(pc >> 2) % 256] >= 2;
      if (pj) ppc = pc + off;
    end
  endfunction

  function automatic int find_pop(input logic [31:0] pc);
    int idx = -1;
    foreach (pop_log[k]) if (pop_log[k].pc == pc) idx = k;
    return idx;
  endfunction

  task automatic step();
    bit          exp_req, popd, dlv, spur_ok, req_seen;
    bit          pj;
    logic [31:0] ppc, addr_seen;
    ent_t        h;
    dlv     = rst_n && rdy && ic_pend && (ic_cnt == 0);
    spur_ok = !ic_pend || !rdy || rollback;
    if (dlv) begin
      IC_val_sgn = 1'b1;
      IC_val     = rand_prog ? rand_inst() : prog(ic_addr);
    end else begin
      IC_val_sgn = spur_ok && (force_sgn || (spur_en && ($urandom_range(0, 3) == 0)));
      IC_val     = $urandom;
    end
    #1;
    exp_req = rst_n && rdy && !rollback && !m_out &&
              ((m_q.size() < Depth) || ((m_q.size() > 0) && ID_ready));
    popd    = rst_n && rdy && !rollback && (m_q.size() > 0) && ID_ready;
    if (m_init) begin
      if (m_q.size() > 0) h = m_q[0];
      else h = '{32'h0, 32'h0, 1'b0, 32'h0};
      chk("IC_addr_sgn", {31'h0, IC_addr_sgn}, {31'h0, exp_req});
      chk("IC_addr", IC_addr, m_pc);
      chk("ID_valid", {31'h0, ID_valid}, {31'h0, m_q.size() > 0});
      chk("ID_inst", ID_inst, h.inst);
      chk("ID_pc", ID_pc, h.pc);
      chk("ID_pred_jump", {31'h0, ID_pred_jump}, {31'h0, h.pj});
      chk("ID_pred_pc", ID_pred_pc, h.ppc);
    end
    if (popd) pop_log.push_back('{ID_inst, ID_pc, ID_pred_jump, ID_pred_pc});
    req_seen  = (IC_addr_sgn === 1'b1);
    addr_seen = IC_addr;
    if (req_seen) begin
      req_log.push_back(addr_seen);
      req_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_init  = 1'b1;
      m_pc    = 32'h0;
      m_out   = 1'b0;
      ic_pend = 1'b0;
      m_q.delete();
      foreach (m_bht[k]) m_bht[k] = 1;
    end else if (rdy) begin
      predict(IC_val, m_pc, pj, ppc);
      if (rollback) begin
        m_pc    = rollback_pc;
        m_out   = 1'b0;
        ic_pend = 1'b0;
        m_q.delete();
      end else begin
        if (popd) void'(m_q.pop_front());
        if (exp_req) begin
          m_out = 1'b1;
        end else if (m_out && IC_val_sgn) begin
          m_q.push_back('{IC_val, m_pc, pj, ppc});
          m_pc  = ppc;
          m_out = 1'b0;
        end
        if (req_seen) begin
          ic_pend = 1'b1;
          ic_addr = addr_seen;
          ic_cnt  = ic_lat;
        end else if (dlv) begin
          ic_pend = 1'b0;
        end else if (ic_pend && ic_cnt > 0) begin
          ic_cnt--;
        end
      end
      if (BR_upd) begin
        if (BR_taken) m_bht[(BR_pc >> 2) % 256] = (m_bht[(BR_pc >> 2) % 256] == 3) ? 3 :
                                                  m_bht[(BR_pc >> 2) % 256] + 1;
        else m_bht[(BR_pc >> 2) % 256] = (m_bht[(BR_pc >> 2) % 256] == 0) ? 0 :
                                         m_bht[(BR_pc >> 2) % 256] - 1;
      end
    end
    #1;
  endtask

  initial begin
    int idx, nreq;
    logic [31:0] exp_req_pc[9];
    exp_req_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h24};
    n_pass = 0; n_total = 0; cyc = 0;
    m_init = 1'b0; m_out = 1'b0; m_pc = 32'h0; ic_pend = 1'b0; ic_cnt = 0; ic_lat = 0;
    ic_addr = 32'h0; rand_prog = 1'b0; spur_en = 1'b0; force_sgn = 1'b0;
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0; IC_val = 32'h0;
    IC_val_sgn = 1'b0; BR_upd = 1'b0; BR_pc = 32'h0; BR_taken = 1'b0; ID_ready = 1'b1;
    @(negedge clk);

    // Reset then sequential fetch with 1-cycle icache hits, through the JAL and branch
    step(); step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("req_count", req_log.size() >= 9, 1);
    for (int k = 0; k < 9 && k < req_log.size(); k++) chk("req_pc", req_log[k], exp_req_pc[k]);
    for (int k = 0; k < 4 && k + 1 < req_cyc.size(); k++)
      chk("req_spacing", req_cyc[k+1] - req_cyc[k], 2);
    idx = find_pop(32'h0);
    chk("pop0_found", idx >= 0, 1);
    if (idx >= 0) chk("pop0_pred_pc", pop_log[idx].ppc, 32'h4);
    idx = find_pop(32'h10);
    chk("jal_found", idx >= 0, 1);
    if (idx >= 0) begin
      chk("jal_pred_jump", {31'h0, pop_log[idx].pj}, 1);
      chk("jal_pred_pc", pop_log[idx].ppc, 32'h18);
    end
    idx = find_pop(32'h20);
    chk("br_nt_found", idx >= 0, 1);
    if (idx >= 0) chk("br_nt_pred_pc", pop_log[idx].ppc, 32'h24);

    // Train the branch to taken, then refetch it
    BR_upd = 1'b1; BR_pc = 32'h20; BR_taken = 1'b1;
    step(); step();
    BR_upd = 1'b0;
    rollback = 1'b1; rollback_pc = 32'h20;
    step();
    rollback = 1'b0;
    pop_log.delete();
    repeat (6) step();
    idx = find_pop(32'h20);
    chk("br_t_found", idx >= 0, 1);
    if (idx >= 0) begin
      chk("br_t_pred_jump", {31'h0, pop_log[idx].pj}, 1);
      chk("br_t_pred_pc", pop_log[idx].ppc, 32'h1C);
    end

    // Fill the queue with the decoder stalled; a single pop earns a single request
    ID_ready = 1'b0;
    rollback = 1'b1; rollback_pc = 32'h40;
    step();
    rollback = 1'b0;
    nreq = req_log.size();
    repeat (40) step();
    chk("full_reqs", req_log.size() - nreq, Depth);
    ic_lat = 10;
    ID_ready = 1'b1;
    nreq = req_log.size();
    step();
    chk("pop_req", req_log.size() - nreq, 1);

    // Miss, rolled back in its fifth cycle while a stray response pulses
    ID_ready = 1'b0;
    repeat (4) step();
    rollback = 1'b1; rollback_pc = 32'h100; force_sgn = 1'b1;
    step();
    rollback = 1'b0; force_sgn = 1'b0; ic_lat = 3;
    #1;
    chk("rb_empty", {31'h0, ID_valid}, 0);
    chk("rb_req", {31'h0, IC_addr_sgn}, 1);
    chk("rb_req_pc", IC_addr, 32'h100);
    step();
    step();

    // Freeze mid-WAIT with the decoder ready and the response line pulsing
    ID_ready = 1'b1;
    rdy = 1'b0; force_sgn = 1'b1;
    repeat (3) step();
    rdy = 1'b1; force_sgn = 1'b0;
    repeat (8) step();

    // Random traffic
    rand_prog = 1'b1; spur_en = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      rst_n       = !(n == 600);
      rdy         = ($urandom_range(0, 9) != 0);
      rollback    = ($urandom_range(0, 29) == 0);
      rollback_pc = $urandom_range(0, 255) << 2;
      ID_ready    = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      BR_upd      = ($urandom_range(0, 2) == 0);
      BR_pc       = $urandom_range(0, 63) << 2;
      BR_taken    = $urandom_range(0, 1) == 1;
      ic_lat      = $urandom_range(0, 3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch stage directly upstream of the icache and directly downstream-facing to the decoder. It holds the PC and issues one fetch request at a time to the icache. Returned instructions are predecoded to predict the next PC (JAL target, 2-bit BHT for conditional branches) and pushed with their PC and prediction into an internal instruction queue that the decoder drains. On rollback it redirects the PC and flushes the queue.

## Interface
- `RESET_PC`, 32'h0, PC loaded at reset
- `IQ_DEPTH`, 16, instruction queue entries (power of two)
- `BHT_BITS`, 8, BHT index width; index = pc[BHT_BITS+1:2]

- `clk`, in, 1, single clock, rising edge
- `rst_n`, in, 1, synchronous active-low reset, sampled on `clk` rising edge
- `rdy`, in, 1, global enable; low freezes all state
- `rollback`, in, 1, flush request from ROB
- `rollback_pc`, in, 32, redirect target
- `IC_addr`, out, 32, fetch address, equals `pc`
- `IC_addr_sgn`, out, 1, one-cycle fetch request
- `IC_val`, in, 32, returned instruction
- `IC_val_sgn`, in, 1, `IC_val` valid
- `BR_upd`, in, 1, BHT update strobe
- `BR_pc`, in, 32, PC of the resolved branch
- `BR_taken`, in, 1, resolved direction
- `ID_valid`, out, 1, queue head valid (count != 0)
- `ID_ready`, in, 1, decoder pops head when `ID_valid` and `ID_ready`
- `ID_inst`, out, 32, head instruction
- `ID_pc`, out, 32, head PC
- `ID_pred_jump`, out, 1, head predicted taken
- `ID_pred_pc`, out, 32, head predicted next PC

## Operation
- FSM has 2 states, IDLE and WAIT.
- IDLE
  - If `count < IQ_DEPTH`, or a pop happens this cycle: assert `IC_addr_sgn`=1 for exactly this cycle, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT
  - `IC_addr_sgn`=0. `IC_addr` is held at `pc`, which the icache needs stable for the miss fill.
  - On `IC_val_sgn`=1: push {IC_val, pc, pred_jump, pred_pc}, set `pc <= pred_pc`, go to IDLE.
- `IC_val_sgn` is ignored in IDLE.
- Only one request is outstanding, so a push never meets a full queue.
- Predecode uses opcode = `IC_val[6:0]`:
  - 1101111 (JAL): pred_jump=1, pred_pc = pc + sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - 1100011 (branch): pred_jump = bht[idx][1]; pred_pc = taken ? pc + sext({i[31],i[7],i[30:25],i[11:8],1'b0}) : pc+4.
  - JALR and all other opcodes: pred_jump=0, pred_pc = pc+4.
  - All adds are 32-bit and wrap modulo 2^32.
- BHT is 2^BHT_BITS 2-bit saturating counters.
  - On `BR_upd`: increment if `BR_taken`, else decrement; saturate at 00 and 11.
  - Index is `BR_pc[BHT_BITS+1:2]`.
- Queue is a circular buffer with head/tail pointers that wrap at IQ_DEPTH, plus a count (0..IQ_DEPTH).
  - Push and pop in the same cycle leaves count unchanged.
  - There is no bypass: a pushed entry is visible at the head the next cycle at the earliest.
- Rollback (when `rdy`=1):
  - pc <= `rollback_pc`, state <= IDLE, queue emptied (count=0, head=tail).
  - Any push or pop that cycle is discarded.
  - `IC_addr_sgn`=0 that cycle.
  - A BHT update in the same cycle still applies.
- Responses to pre-rollback requests are not delivered, because the memory controller and icache drop them on rollback.
- Priority: reset > !rdy > rollback > normal.

## Timing
- Reset (`rst_n`=0 at an edge):
  - pc=RESET_PC, state=IDLE, count=0, head=tail=0.
  - All BHT counters = 01 (weakly not-taken).
  - Outputs: `IC_addr_sgn`=0, `ID_valid`=0; ID_* data outputs read as 0.
- `rdy`=0: no state changes, `IC_addr_sgn`=0, no pop is consumed.
- Icache hit:
  - Request in cycle t, `IC_val_sgn` in t+1, push at edge t+2.
  - `ID_valid` in t+2; next request in t+2.
  - Sustained throughput: 1 instruction per 2 cycles.
- Miss: stays in WAIT for any number of cycles until `IC_val_sgn`.
- Rollback at cycle t: first request for `rollback_pc` in t+1.
- `ID_*` are combinational from the head entry. `IC_addr_sgn` is combinational from state, count, `rdy` and `rollback`.

## Test plan
- Reset then sequential fetch:
  - Hold `rst_n`=0 for 2 cycles. The icache model answers every request 1 cycle later with `addi` (32'h00100093).
  - Required: requests at PCs 0,4,8,… every 2 cycles; `ID_pc` 0,4,8 with `ID_pred_pc` = pc+4.
- JAL prediction:
  - At pc=0x10 return 32'h0080006F (jal x0,+8).
  - Required: `ID_pred_jump`=1, `ID_pred_pc`=0x18, next request at 0x18.
- BHT:
  - Branch at 0x20 returns 32'hFE000EE3 (beq, offset −4).
  - Required: first fetch predicted not-taken (0x24).
  - Then two `BR_upd` with `BR_taken`=1 at 0x20, and roll back to 0x20.
  - Required: refetch predicts taken, `ID_pred_pc`=0x1C.
- Full queue:
  - Hold `ID_ready`=0.
  - Required: exactly IQ_DEPTH pushes; `IC_addr_sgn` stays 0 afterwards.
  - Then one pop.
  - Required: exactly one new request issues that cycle.
- Miss plus rollback:
  - The icache model withholds its response for 10 cycles, with `rollback`=1 and `rollback_pc`=0x100 at cycle 5.
  - Required: the queue is empty next cycle, a request for 0x100 issues at cycle 6, and a late response for the old PC is never pushed.
- Freeze:
  - `rdy`=0 for 3 cycles mid-WAIT while `IC_val_sgn` pulses.
  - Required: pc, count and state are unchanged, and there is no pop.
